// File: rtl/hidden_program_feeder.sv
// Program store for the hiddenCPU core: loaded serially MSB-first, replayed by pc_in with a 1-cycle registered fetch.
// Optional HIDDEN_FEEDER_PARITY_EN: 7-bit serial words (6 data bits + odd parity) and a sticky parity_err output.
module hidden_program_feeder #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              load_end,
  input  logic              run_start,
  input  logic              halt,
  input  logic              ser_valid,
  input  logic              ser_bit,
  input  logic [7:0]        pc_in,
  output logic [5:0]        instr_out,
  output logic              instr_valid,
  output logic [ADDR_W:0]   word_count,
  output logic              oob_err,
`ifdef HIDDEN_FEEDER_PARITY_EN
  output logic              parity_err,
`endif
  output logic [1:0]        state_out
);

`ifdef HIDDEN_FEEDER_PARITY_EN
  localparam int WORD_BITS = 7;
`else
  localparam int WORD_BITS = 6;
`endif
  // The shift register holds everything but the bit arriving on the write edge.
  localparam int SHIFT_W = WORD_BITS - 1;
  localparam logic [2:0]        LAST_BIT = 3'(WORD_BITS - 1);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
  localparam logic [7:0]        DEPTH_PC = 8'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10
  } state_t;

  state_t              state_q, state_d;
  logic [SHIFT_W-1:0]  shift_q, shift_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     word_count_q, word_count_d;
  logic [5:0]          instr_q, instr_d;
  logic                instr_vld_q, instr_vld_d;
  logic                oob_q, oob_d;
  logic [5:0]          mem_q [DEPTH];
  logic                wr_en;
  logic [5:0]          wr_dat;
`ifdef HIDDEN_FEEDER_PARITY_EN
  logic                par_err_q, par_err_d;
  logic                par_ok;
`endif

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    wr_ptr_d     = wr_ptr_q;
    word_count_d = word_count_q;
    instr_d      = '0;
    instr_vld_d  = 1'b0;
    oob_d        = oob_q;
    wr_en        = 1'b0;
`ifdef HIDDEN_FEEDER_PARITY_EN
    par_err_d    = par_err_q;
    par_ok       = ^{shift_q, ser_bit};
    wr_dat       = par_ok ? shift_q : 6'b000000;
`else
    wr_dat       = {shift_q, ser_bit};
`endif

    if (state_q == ST_RUN) begin
      instr_vld_d = 1'b1;
      if (pc_in >= DEPTH_PC) begin
        oob_d = 1'b1;
      end else begin
        instr_d = mem_q[pc_in[ADDR_W-1:0]];
      end
    end

    if (load_start) begin
      state_d      = ST_LOAD;
      shift_d      = '0;
      bit_cnt_d    = '0;
      wr_ptr_d     = '0;
      word_count_d = '0;
      oob_d        = 1'b0;
`ifdef HIDDEN_FEEDER_PARITY_EN
      par_err_d    = 1'b0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: if (run_start) state_d = ST_RUN;
        ST_LOAD: begin
          if (ser_valid) begin
            if (bit_cnt_q == LAST_BIT) begin
              wr_en        = 1'b1;
              shift_d      = '0;
              bit_cnt_d    = '0;
              wr_ptr_d     = wr_ptr_q + 1'b1;
              word_count_d = word_count_q + 1'b1;
`ifdef HIDDEN_FEEDER_PARITY_EN
              if (!par_ok) par_err_d = 1'b1;
`endif
              if (wr_ptr_q == LAST_PTR) state_d = ST_RUN;
            end else begin
              shift_d   = {shift_q[SHIFT_W-2:0], ser_bit};
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
          // A partial word pending at load_end is simply dropped.
          if (load_end) begin
            state_d   = ST_RUN;
            shift_d   = '0;
            bit_cnt_d = '0;
          end
        end
        ST_RUN:  if (halt) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      wr_ptr_q     <= '0;
      word_count_q <= '0;
      instr_q      <= '0;
      instr_vld_q  <= 1'b0;
      oob_q        <= 1'b0;
`ifdef HIDDEN_FEEDER_PARITY_EN
      par_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      word_count_q <= word_count_d;
      instr_q      <= instr_d;
      instr_vld_q  <= instr_vld_d;
      oob_q        <= oob_d;
`ifdef HIDDEN_FEEDER_PARITY_EN
      par_err_q    <= par_err_d;
`endif
    end
  end

  // Program store is flop-based so reset can clear every word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_dat;
    end
  end

  assign instr_out   = instr_q;
  assign instr_valid = instr_vld_q;
  assign word_count  = word_count_q;
  assign oob_err     = oob_q;
  assign state_out   = state_q;
`ifdef HIDDEN_FEEDER_PARITY_EN
  assign parity_err  = par_err_q;
`endif

endmodule

// File: tb/tb_hidden_program_feeder.sv
// Directed bench for hidden_program_feeder: load, replay, auto-RUN, out-of-range pc, reset mid-load.
module tb_hidden_program_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_start, load_end, run_start, halt, ser_valid, ser_bit;
  logic [7:0] pc_in;
  logic [5:0] instr_out;
  logic       instr_valid;
  logic [4:0] word_count;
  logic       oob_err;
  logic [1:0] state_out;
`ifdef HIDDEN_FEEDER_PARITY_EN
  logic       parity_err;
  localparam int WB = 7;
`else
  localparam int WB = 6;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [5:0] pat [16];

  always #5 clk = ~clk;

  hidden_program_feeder #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .load_end   (load_end),
    .run_start  (run_start),
    .halt       (halt),
    .ser_valid  (ser_valid),
    .ser_bit    (ser_bit),
    .pc_in      (pc_in),
    .instr_out  (instr_out),
    .instr_valid(instr_valid),
    .word_count (word_count),
    .oob_err    (oob_err),
`ifdef HIDDEN_FEEDER_PARITY_EN
    .parity_err (parity_err),
`endif
    .state_out  (state_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load_start();
    load_start = 1'b1; tick(); load_start = 1'b0;
  endtask

  task automatic pulse_load_end();
    load_end = 1'b1; tick(); load_end = 1'b0;
  endtask

  // Sends w MSB-first; in the parity build p follows as the 7th bit.
  task automatic send_word(input logic [5:0] w, input logic p);
    logic [6:0] v;
    v = {w, p};
    for (int i = 0; i < WB; i++) begin
      ser_valid = 1'b1;
      ser_bit   = v[6-i];
      tick();
    end
    ser_valid = 1'b0;
    ser_bit   = 1'b0;
  endtask

  function automatic logic oddpar(input logic [5:0] w);
    return ~^w;
  endfunction

  task automatic fetch(input string tag, input logic [7:0] pc, input logic [5:0] exp);
    pc_in = pc;
    tick();
    chk(tag, 32'(instr_out), 32'(exp));
  endtask

  initial begin
    rst = 1'b0; load_start = 0; load_end = 0; run_start = 0; halt = 0;
    ser_valid = 0; ser_bit = 0; pc_in = 8'd0;
    for (int i = 0; i < 16; i++) pat[i] = 6'(i * 5 + 1);
    tick(); tick();
    chk("rst_state", 32'(state_out), 32'd0);
    chk("rst_instr", 32'(instr_out), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_wc", 32'(word_count), 32'd0);
    chk("rst_oob", 32'(oob_err), 32'd0);
    rst = 1'b1;
    tick();

    // Basic two-word load and replay
    pulse_load_start();
    chk("t1_load_state", 32'(state_out), 32'd1);
    send_word(6'b101101, oddpar(6'b101101));
    send_word(6'b010011, oddpar(6'b010011));
    chk("t1_wc", 32'(word_count), 32'd2);
    pulse_load_end();
    chk("t1_run_state", 32'(state_out), 32'd2);
    chk("t1_valid_lat", 32'(instr_valid), 32'd0);
    fetch("t1_pc0", 8'd0, 6'b101101);
    chk("t1_valid", 32'(instr_valid), 32'd1);
    fetch("t1_pc1", 8'd1, 6'b010011);
    chk("t1_wc_run", 32'(word_count), 32'd2);

    // Partial trailing word is discarded
    pulse_load_start();
    chk("t2_wc_clr", 32'(word_count), 32'd0);
    send_word(6'b111000, oddpar(6'b111000));
    send_word(6'b000111, oddpar(6'b000111));
    send_word(6'b110011, oddpar(6'b110011));
    for (int i = 0; i < 4; i++) begin
      ser_valid = 1'b1; ser_bit = 1'b1; tick();
    end
    ser_valid = 1'b0;
    pulse_load_end();
    chk("t2_wc", 32'(word_count), 32'd3);
    fetch("t2_pc3", 8'd3, 6'b000000);
    fetch("t2_pc2", 8'd2, 6'b110011);
    fetch("t2_pc0", 8'd0, 6'b111000);

    // Full load auto-enters RUN
    pulse_load_start();
    for (int i = 0; i < 15; i++) send_word(pat[i], oddpar(pat[i]));
    chk("t3_still_load", 32'(state_out), 32'd1);
    send_word(pat[15], oddpar(pat[15]));
    chk("t3_auto_run", 32'(state_out), 32'd2);
    chk("t3_wc", 32'(word_count), 32'd16);
    fetch("t3_pc15", 8'd15, 6'b001100);
    fetch("t3_pc7", 8'd7, 6'b100100);

    // Out-of-range pc
    chk("t4_oob_pre", 32'(oob_err), 32'd0);
    fetch("t4_pc20", 8'd20, 6'b000000);
    chk("t4_oob_set", 32'(oob_err), 32'd1);
    fetch("t4_pc16", 8'd16, 6'b000000);
    fetch("t4_pc0", 8'd0, 6'b000001);
    chk("t4_oob_held", 32'(oob_err), 32'd1);
    pulse_load_start();
    chk("t4_oob_clr", 32'(oob_err), 32'd0);
    chk("t4_state", 32'(state_out), 32'd1);

    // halt / run_start and outputs clearing outside RUN
    pulse_load_end();
    halt = 1'b1; tick(); halt = 1'b0;
    chk("t5_idle", 32'(state_out), 32'd0);
    chk("t5_valid_lag", 32'(instr_valid), 32'd1);
    tick();
    chk("t5_valid_off", 32'(instr_valid), 32'd0);
    chk("t5_instr_off", 32'(instr_out), 32'd0);
    load_end = 1'b1; tick(); load_end = 1'b0;
    chk("t5_ign_end", 32'(state_out), 32'd0);
    run_start = 1'b1; tick(); run_start = 1'b0;
    chk("t5_run", 32'(state_out), 32'd2);

    // load_start beats halt; reset mid-load wipes everything
    load_start = 1'b1; halt = 1'b1; tick(); load_start = 1'b0; halt = 1'b0;
    chk("t6_prio", 32'(state_out), 32'd1);
    for (int i = 0; i < 3; i++) begin
      ser_valid = 1'b1; ser_bit = 1'b1; tick();
    end
    ser_valid = 1'b0;
    rst = 1'b0;
    #2;
    chk("t6_rst_state", 32'(state_out), 32'd0);
    chk("t6_rst_valid", 32'(instr_valid), 32'd0);
    chk("t6_rst_wc", 32'(word_count), 32'd0);
    rst = 1'b1;
    run_start = 1'b1; tick(); run_start = 1'b0;
    for (int i = 0; i < 16; i++) fetch($sformatf("t6_mem%0d", i), 8'(i), 6'b000000);

`ifdef HIDDEN_FEEDER_PARITY_EN
    pulse_load_start();
    send_word(6'b101101, 1'b1);
    chk("par_ok_err", 32'(parity_err), 32'd0);
    send_word(6'b101101, 1'b0);
    chk("par_bad_err", 32'(parity_err), 32'd1);
    chk("par_wc", 32'(word_count), 32'd2);
    pulse_load_end();
    fetch("par_pc0", 8'd0, 6'b101101);
    fetch("par_pc1", 8'd1, 6'b000000);
    pulse_load_start();
    chk("par_clr", 32'(parity_err), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
